// File: rtl/mdu_controller.sv
// -----------------------------------------------------------------------------
// mdu_controller
//
// Multiply/divide unit controller for a five-stage pipeline. It keeps the
// architectural HI/LO registers and runs mult/multu/div/divu as fixed-latency
// operations. The result is computed in the issue cycle and held in shadow
// registers. It becomes architecturally visible only when the busy window ends.
//
// Ports:
//   clk       in   1  clock, all state updates on rising edge
//   reset     in   1  asynchronous active-high reset
//   start     in   1  E-stage MDU instruction valid this cycle
//   op        in   3  001 mult, 010 multu, 011 div, 100 divu, 101 mthi,
//                     110 mtlo; 000 / 111 are no-ops
//   a         in  32  rs operand (forwarded)
//   b         in  32  rt operand (forwarded)
//   d_md_use  in   1  D-stage instruction is an MDU instruction
//   busy      out  1  multi-cycle operation in progress
//   stall     out  1  freeze PC/F/D and bubble E
//   hi        out 32  architectural HI
//   lo        out 32  architectural LO
// -----------------------------------------------------------------------------
module mdu_controller #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        d_md_use,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   // Unsigned divide returning {remainder, quotient}. The caller guarantees
   // that d is non-zero.
   function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
      logic [31:0] q;
      logic [31:0] r;
      q = n / d;
      r = n % d;
      return {r, q};
   endfunction

   // Signed divide done on magnitudes. This avoids the host-level overflow of
   // INT_MIN / -1. Negating the magnitude quotient 0x80000000 yields
   // 0x80000000 again, which gives the required wrapped result. The quotient
   // truncates toward zero. The remainder follows the dividend's sign.
   function automatic logic [63:0] div_signed(input logic [31:0] n, input logic [31:0] d);
      logic [31:0] un;
      logic [31:0] ud;
      logic [31:0] q;
      logic [31:0] r;
      un = n[31] ? (~n + 32'd1) : n;
      ud = d[31] ? (~d + 32'd1) : d;
      q  = un / ud;
      r  = un % ud;
      if (n[31] ^ d[31]) begin
         q = ~q + 32'd1;
      end else begin
         q = q;
      end
      if (n[31]) begin
         r = ~r + 32'd1;
      end else begin
         r = r;
      end
      return {r, q};
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      sh_hi_q, sh_hi_d;
   logic [31:0]      sh_lo_q, sh_lo_d;
   // Cleared for divide-by-zero so that completion leaves HI/LO untouched.
   logic             sh_vld_q, sh_vld_d;

   logic             is_muldiv;
   logic [63:0]      prod_s;
   logic [63:0]      prod_u;
   logic [31:0]      div_d;
   logic [63:0]      quo_s;
   logic [63:0]      quo_u;

   // Arithmetic datapath. Both operands are extended to 64 bits so the low
   // 64 bits of the product are exact for both signednesses.
   always_comb begin
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};
      // Feed a harmless divisor when b is zero. That result is discarded.
      div_d  = (b == 32'd0) ? 32'd1 : b;
      quo_s  = div_signed(a, div_d);
      quo_u  = div_unsigned(a, div_d);
   end

   // Next-state, counter, shadow and HI/LO update logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      sh_hi_d  = sh_hi_q;
      sh_lo_d  = sh_lo_q;
      sh_vld_d = sh_vld_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     sh_hi_d  = prod_s[63:32];
                     sh_lo_d  = prod_s[31:0];
                     sh_vld_d = 1'b1;
                     cnt_d    = MULT_LOAD;
                     state_d  = S_RUN;
                  end
                  OP_MULTU: begin
                     sh_hi_d  = prod_u[63:32];
                     sh_lo_d  = prod_u[31:0];
                     sh_vld_d = 1'b1;
                     cnt_d    = MULT_LOAD;
                     state_d  = S_RUN;
                  end
                  OP_DIV: begin
                     if (b != 32'd0) begin
                        sh_hi_d = quo_s[63:32];
                        sh_lo_d = quo_s[31:0];
                     end else begin
                        sh_hi_d = sh_hi_q;
                     end
                     sh_vld_d = (b != 32'd0);
                     cnt_d    = DIV_LOAD;
                     state_d  = S_RUN;
                  end
                  OP_DIVU: begin
                     if (b != 32'd0) begin
                        sh_hi_d = quo_u[63:32];
                        sh_lo_d = quo_u[31:0];
                     end else begin
                        sh_hi_d = sh_hi_q;
                     end
                     sh_vld_d = (b != 32'd0);
                     cnt_d    = DIV_LOAD;
                     state_d  = S_RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: hi_d = hi_q;
               endcase
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            // Any start seen here is ignored.
            if (cnt_q <= CNT_ONE) begin
               cnt_d    = CNT_ZERO;
               state_d  = S_IDLE;
               sh_vld_d = 1'b0;
               if (sh_vld_q) begin
                  hi_d = sh_hi_q;
                  lo_d = sh_lo_q;
               end else begin
                  hi_d = hi_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // State, counter, shadow and architectural register storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= CNT_ZERO;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         sh_hi_q  <= 32'd0;
         sh_lo_q  <= 32'd0;
         sh_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         sh_hi_q  <= sh_hi_d;
         sh_lo_q  <= sh_lo_d;
         sh_vld_q <= sh_vld_d;
      end
   end

   // Output decode. Stall also covers the issue cycle of a multi-cycle op.
   always_comb begin
      is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
      busy      = (state_q == S_RUN);
      stall     = d_md_use & (busy | (start & is_muldiv));
      hi        = hi_q;
      lo        = lo_q;
   end

endmodule

// File: tb/tb_mdu_controller.sv
// -----------------------------------------------------------------------------
// tb_mdu_controller
//
// Self-checking bench for mdu_controller. Table-driven vectors push their
// expected {hi, lo, busy length} into a scoreboard queue when issued. The
// entries are popped and compared when the operation completes. Hand-written
// sequences cover stall, start-while-busy and reset-mid-RUN.
// -----------------------------------------------------------------------------
module tb_mdu_controller;

   localparam logic [2:0] OP_NOP0  = 3'b000;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam logic [2:0] OP_NOP7  = 3'b111;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        d_md_use;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_busy;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          busy;
   } sb_t;

   sb_t sb_q[$];

   mdu_controller #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .d_md_use (d_md_use),
      .busy     (busy),
      .stall    (stall),
      .hi       (hi),
      .lo       (lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Independent reference: 64-bit host arithmetic, no magnitude tricks.
   task automatic model(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] ph, input logic [31:0] pl,
                        output logic [31:0] eh, output logic [31:0] el, output int eb);
      longint      sa, sb, p, q, r;
      logic [63:0] pu;
      eh = ph; el = pl; eb = 0;
      sa = longint'($signed(va));
      sb = longint'($signed(vb));
      case (o)
         OP_MULT:  begin p = sa * sb; eh = p[63:32]; el = p[31:0]; eb = 5; end
         OP_MULTU: begin pu = {32'd0, va} * {32'd0, vb}; eh = pu[63:32]; el = pu[31:0]; eb = 5; end
         OP_DIV: begin
            eb = 10;
            if (vb != 32'd0) begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
         end
         OP_DIVU: begin
            eb = 10;
            if (vb != 32'd0) begin el = va / vb; eh = va % vb; end
         end
         OP_MTHI: eh = va;
         OP_MTLO: el = va;
         default: eb = 0;
      endcase
   endtask

   // Issue one op for a single cycle. On return we sit on the negedge after
   // the issue edge.
   task automatic drive_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
      @(negedge clk);
      start = 1'b1; op = o; a = va; b = vb;
      @(negedge clk);
      start = 1'b0; op = OP_NOP0; a = 32'd0; b = 32'd0;
   endtask

   // Wait for completion, pop the scoreboard and compare.
   task automatic observe(input string name, input logic [31:0] ph, input logic [31:0] pl);
      sb_t e;
      int  n;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s_sb: scoreboard empty, got 0 entries expected 1", name);
         return;
      end
      e = sb_q.pop_front();
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         if (n == 0) begin
            check({name, "_hold_hi"}, hi, ph);
            check({name, "_hold_lo"}, lo, pl);
         end
         n++;
         @(negedge clk);
      end
      check({name, "_busy_len"}, 32'(n), 32'(e.busy));
      check({name, "_hi"}, hi, e.hi);
      check({name, "_lo"}, lo, e.lo);
   endtask

   vec_t        vecs[$];
   logic [31:0] ph, pl, eh, el;
   int          eb, n, sn;

   initial begin
      reset = 1'b1; start = 1'b0; op = OP_NOP0; a = 32'd0; b = 32'd0; d_md_use = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      reset = 1'b0; d_md_use = 1'b0;

      vecs.push_back('{OP_MTLO,  32'h00000022, 32'h0,        32'h00000000, 32'h00000022, 0});
      vecs.push_back('{OP_MTHI,  32'h00000011, 32'h0,        32'h00000011, 32'h00000022, 0});
      vecs.push_back('{OP_DIVU,  32'h00000005, 32'h0,        32'h00000011, 32'h00000022, 10});
      vecs.push_back('{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5});
      vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5});
      vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10});
      vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10});
      vecs.push_back('{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10});
      vecs.push_back('{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10});
      vecs.push_back('{OP_NOP0,  32'hAAAA5555, 32'h1,        32'h00000001, 32'hFFFFFFFD, 0});
      vecs.push_back('{OP_NOP7,  32'h5555AAAA, 32'h2,        32'h00000001, 32'hFFFFFFFD, 0});

      ph = 32'd0; pl = 32'd0;
      for (int i = 0; i < vecs.size(); i++) begin
         sb_q.push_back('{vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_busy});
         drive_op(vecs[i].op, vecs[i].a, vecs[i].b);
         observe($sformatf("vec%0d", i), ph, pl);
         ph = vecs[i].exp_hi; pl = vecs[i].exp_lo;
      end

      // Randomised ops against the host-arithmetic model.
      for (int i = 0; i < 8; i++) begin
         logic [2:0]  ro;
         logic [31:0] ra, rb;
         ro = 3'($urandom_range(1, 6));
         ra = $urandom;
         rb = (i == 3) ? 32'd0 : $urandom;
         model(ro, ra, rb, ph, pl, eh, el, eb);
         sb_q.push_back('{eh, el, eb});
         drive_op(ro, ra, rb);
         observe($sformatf("rnd%0d", i), ph, pl);
         ph = eh; pl = el;
      end

      // Stall with d_md_use held: issue cycle + 5 RUN cycles.
      d_md_use = 1'b1;
      @(negedge clk);
      start = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd4;
      #1;
      sn = (stall === 1'b1) ? 1 : 0;
      @(negedge clk);
      start = 1'b0; op = OP_NOP0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         if (stall === 1'b1) sn++;
         n++;
         @(negedge clk);
      end
      if (stall === 1'b1) sn++;
      check("stall_cycles", 32'(sn), 32'd6);
      check("stall_mult_lo", lo, 32'd12);

      // The same with d_md_use low: stall never rises.
      d_md_use = 1'b0;
      @(negedge clk);
      start = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
      #1;
      sn = (stall === 1'b1) ? 1 : 0;
      @(negedge clk);
      start = 1'b0; op = OP_NOP0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         if (stall === 1'b1) sn++;
         n++;
         @(negedge clk);
      end
      check("nostall_cycles", 32'(sn), 32'd0);
      check("nostall_busy_len", 32'(n), 32'd5);

      // A start during RUN must be ignored.
      drive_op(OP_MULT, 32'd7, 32'd6);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         if (n == 2) begin
            start = 1'b1; op = OP_MTHI; a = 32'hDEADBEEF;
         end else begin
            start = 1'b0; op = OP_NOP0; a = 32'd0;
         end
         @(negedge clk);
      end
      start = 1'b0; op = OP_NOP0;
      check("ignore_busy_len", 32'(n), 32'd5);
      check("ignore_hi", hi, 32'd0);
      check("ignore_lo", lo, 32'd42);

      // Reset in cycle 4 of a divide aborts it and never commits.
      d_md_use = 1'b1;
      drive_op(OP_DIV, 32'd100, 32'd3);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rstrun_busy", {31'd0, busy}, 32'd0);
      check("rstrun_stall", {31'd0, stall}, 32'd0);
      check("rstrun_hi", hi, 32'd0);
      check("rstrun_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check("postrst_busy", {31'd0, busy}, 32'd0);
      check("postrst_hi", hi, 32'd0);
      check("postrst_lo", lo, 32'd0);
      d_md_use = 1'b0;
      sb_q.push_back('{32'd0, 32'h00001234, 0});
      drive_op(OP_MTLO, 32'h00001234, 32'd0);
      observe("mtlo_after_rst", 32'd0, 32'd0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
